// File: rtl/cmp_sched_pkg.sv
// Shared types and constants for the compare-unit scheduler.
package cmp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] CMP_SEL_MIN = 3'd2;
  localparam logic [2:0] CMP_SEL_MAX = 3'd7;

  localparam logic REQ_BR  = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  // Latency counter width; covers CMP_LAT 0..3
  localparam int unsigned CNT_W = 2;

  function automatic logic [1:0] id_onehot(input logic id);
    return (id == REQ_DBG) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; the requester other than last wins a tie.
module rr_arb2
  import cmp_sched_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt    = 2'b00;
    gnt_id = REQ_BR;
    case (req)
      2'b01: begin
        gnt    = 2'b01;
        gnt_id = REQ_BR;
      end
      2'b10: begin
        gnt    = 2'b10;
        gnt_id = REQ_DBG;
      end
      2'b11: begin
        gnt_id = ~last;
        gnt    = id_onehot(~last);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cmp_sched.sv
// Sequencer sharing the ALU comparison unit between the branch unit and the loop/debug unit.
module cmp_sched
  import cmp_sched_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned CMP_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] req_a_0,
  input  logic [N-1:0] req_b_0,
  input  logic [2:0]   req_sel_0,
  input  logic [N-1:0] req_a_1,
  input  logic [N-1:0] req_b_1,
  input  logic [2:0]   req_sel_1,
  output logic [N-1:0] cmp_a,
  output logic [N-1:0] cmp_b,
  output logic [2:0]   cmp_sel,
  input  logic [N-1:0] cmp_result,
  output logic [1:0]   resp_valid,
  input  logic [1:0]   resp_ready,
  output logic [N-1:0] resp_data,
  output logic         resp_err,
  output logic         busy
);

  state_t           r_state;
  logic             r_rr_last;
  logic             r_id;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0]       w_gnt;
  logic             w_gnt_id;
  logic [N-1:0]     w_a;
  logic [N-1:0]     w_b;
  logic [2:0]       w_sel;

  rr_arb2 u_arb (
    .req    (req_valid),
    .last   (r_rr_last),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id)
  );

  assign w_a   = (w_gnt_id == REQ_DBG) ? req_a_1   : req_a_0;
  assign w_b   = (w_gnt_id == REQ_DBG) ? req_b_1   : req_b_0;
  assign w_sel = (w_gnt_id == REQ_DBG) ? req_sel_1 : req_sel_0;

  // Grant is only offered while idle; gated by rst_n so every output reads 0 in reset
  assign req_ready = ((r_state == IDLE) && rst_n) ? w_gnt : 2'b00;

  // The latched operands live directly in cmp_a/cmp_b/cmp_sel, which are zero outside EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rr_last  <= 1'b1;
      r_id       <= 1'b0;
      r_cnt      <= '0;
      cmp_a      <= '0;
      cmp_b      <= '0;
      cmp_sel    <= 3'd0;
      resp_valid <= 2'b00;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt != 2'b00) begin
            r_id <= w_gnt_id;
            busy <= 1'b1;
            if (w_sel < CMP_SEL_MIN) begin
              r_state    <= RESP;
              resp_data  <= '0;
              resp_err   <= 1'b1;
              resp_valid <= id_onehot(w_gnt_id);
            end else begin
              r_state <= EXEC;
              cmp_a   <= w_a;
              cmp_b   <= w_b;
              cmp_sel <= w_sel;
              r_cnt   <= CNT_W'(CMP_LAT);
            end
          end
        end
        EXEC: begin
          if (r_cnt == '0) begin
            r_state    <= RESP;
            resp_data  <= cmp_result;
            resp_err   <= 1'b0;
            resp_valid <= id_onehot(r_id);
            cmp_a      <= '0;
            cmp_b      <= '0;
            cmp_sel    <= 3'd0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if ((resp_valid & resp_ready) != 2'b00) begin
            r_state    <= IDLE;
            r_rr_last  <= r_id;
            resp_valid <= 2'b00;
            busy       <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_sched.sv
// Scoreboard bench for cmp_sched: transaction-level model, randomized traffic, latency builds.
module tb_cmp_sched;

  localparam int unsigned N   = 8;
  localparam int unsigned LAT = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]   req_valid, req_ready, resp_valid, resp_ready;
  logic [N-1:0] req_a_0, req_b_0, req_a_1, req_b_1;
  logic [2:0]   req_sel_0, req_sel_1, cmp_sel;
  logic [N-1:0] cmp_a, cmp_b, cmp_result, resp_data, dp1;
  logic         resp_err, busy;

  cmp_sched #(.N(N), .CMP_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a_0(req_a_0), .req_b_0(req_b_0), .req_sel_0(req_sel_0),
    .req_a_1(req_a_1), .req_b_1(req_b_1), .req_sel_1(req_sel_1),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_sel(cmp_sel), .cmp_result(cmp_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err), .busy(busy)
  );

  // Extra builds with CMP_LAT=0 (index 0) and CMP_LAT=3 (index 1)
  logic [1:0]   v_req_valid[2], v_req_ready[2], v_resp_valid[2], v_resp_ready[2];
  logic [N-1:0] v_a[2], v_b[2], v_cmp_a[2], v_cmp_b[2], v_res[2], v_resp_data[2];
  logic [2:0]   v_sel[2], v_cmp_sel[2];
  logic         v_err[2], v_busy[2];
  logic [N-1:0] l3_p1, l3_p2, l3_p3;

  cmp_sched #(.N(N), .CMP_LAT(0)) u_l0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v_req_valid[0]), .req_ready(v_req_ready[0]),
    .req_a_0(v_a[0]), .req_b_0(v_b[0]), .req_sel_0(v_sel[0]),
    .req_a_1(v_a[0]), .req_b_1(v_b[0]), .req_sel_1(v_sel[0]),
    .cmp_a(v_cmp_a[0]), .cmp_b(v_cmp_b[0]), .cmp_sel(v_cmp_sel[0]), .cmp_result(v_res[0]),
    .resp_valid(v_resp_valid[0]), .resp_ready(v_resp_ready[0]),
    .resp_data(v_resp_data[0]), .resp_err(v_err[0]), .busy(v_busy[0])
  );

  cmp_sched #(.N(N), .CMP_LAT(3)) u_l3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v_req_valid[1]), .req_ready(v_req_ready[1]),
    .req_a_0(v_a[1]), .req_b_0(v_b[1]), .req_sel_0(v_sel[1]),
    .req_a_1(v_a[1]), .req_b_1(v_b[1]), .req_sel_1(v_sel[1]),
    .cmp_a(v_cmp_a[1]), .cmp_b(v_cmp_b[1]), .cmp_sel(v_cmp_sel[1]), .cmp_result(v_res[1]),
    .resp_valid(v_resp_valid[1]), .resp_ready(v_resp_ready[1]),
    .resp_data(v_resp_data[1]), .resp_err(v_err[1]), .busy(v_busy[1])
  );

  // Comparison datapath: 2 eq, 3 ltu, 4 lts, 5 geu, 6 ges, 7 ne; 0/1 give zero
  function automatic logic [N-1:0] cmp_fn(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [2:0] s);
    logic r;
    case (s)
      3'd2:    r = (a == b);
      3'd3:    r = (a < b);
      3'd4:    r = ($signed(a) < $signed(b));
      3'd5:    r = (a >= b);
      3'd6:    r = ($signed(a) >= $signed(b));
      3'd7:    r = (a != b);
      default: r = 1'b0;
    endcase
    return N'(r);
  endfunction

  always @(posedge clk) dp1 <= cmp_fn(cmp_a, cmp_b, cmp_sel);
  assign cmp_result = dp1;
  assign v_res[0] = cmp_fn(v_cmp_a[0], v_cmp_b[0], v_cmp_sel[0]);
  always @(posedge clk) begin
    l3_p1 <= cmp_fn(v_cmp_a[1], v_cmp_b[1], v_cmp_sel[1]);
    l3_p2 <= l3_p1;
    l3_p3 <= l3_p2;
  end
  assign v_res[1] = l3_p3;

  // Transaction-level reference state
  typedef struct packed {
    logic         id;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   sel;
    logic [N-1:0] data;
    logic         err;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   mdue  = 0;
  int   n_acc = 0;
  bit   mbusy = 1'b0;
  bit   mid   = 1'b0;
  bit   mlast = 1'b1;
  bit   mlegal = 1'b0;
  bit   chk_en = 1'b0;
  logic [1:0] exp_gnt = 2'b00;
  logic [1:0] exp_rv  = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Expected grant and response-valid for the current cycle
  task automatic predict();
    exp_rv = (mbusy && cyc >= mdue) ? (mid ? 2'b10 : 2'b01) : 2'b00;
    if (mbusy)                  exp_gnt = 2'b00;
    else if (req_valid == 2'b11) exp_gnt = mlast ? 2'b01 : 2'b10;
    else                        exp_gnt = req_valid;
  endtask

  // Advance one clock and apply what the previous cycle's handshakes imply
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (mbusy && (exp_rv & resp_ready) != 2'b00) begin
      mbusy = 1'b0;
      mlast = mid;
    end else if (exp_gnt != 2'b00) begin
      e.id   = exp_gnt[1];
      e.a    = e.id ? req_a_1 : req_a_0;
      e.b    = e.id ? req_b_1 : req_b_0;
      e.sel  = e.id ? req_sel_1 : req_sel_0;
      mlegal = (e.sel >= 3'd2);
      e.data = mlegal ? cmp_fn(e.a, e.b, e.sel) : '0;
      e.err  = !mlegal;
      q.push_back(e);
      mbusy = 1'b1;
      mid   = e.id;
      mdue  = cyc + (mlegal ? int'(LAT) + 1 : 0);
      n_acc++;
      req_valid[e.id] = 1'b0;
    end
    predict();
  endtask

  task automatic new_req(input int j, input logic [2:0] sel);
    logic [N-1:0] a, b;
    a = N'($urandom);
    b = ($urandom_range(3) == 0) ? a : N'($urandom);
    if (j == 0) begin req_a_0 = a; req_b_0 = b; req_sel_0 = sel; end
    else        begin req_a_1 = a; req_b_1 = b; req_sel_1 = sel; end
    req_valid[j] = 1'b1;
  endtask

  task automatic run_idle(input int max);
    int i;
    for (i = 0; i < max && (mbusy || req_valid != 2'b00); i++) tick();
    if (i == max) chk("idle_timeout", 32'(i), 32'(max + 1));
  endtask

  task automatic measure(input int k, input int want);
    int lat;
    bit acc, seen;
    v_a[k] = 8'h80; v_b[k] = 8'h7f; v_sel[k] = 3'd4;
    v_req_valid[k] = 2'b01; v_resp_ready[k] = 2'b11;
    acc = 1'b0;
    for (int i = 0; i < 5 && !acc; i++) begin
      @(negedge clk);
      acc = v_req_ready[k][0];
      tick();
    end
    v_req_valid[k] = 2'b00;
    chk("lat_accept", 32'(acc), 32'd1);
    lat = 0; seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (v_resp_valid[k] != 2'b00) begin seen = 1'b1; lat = i; end
      else tick();
    end
    chk("lat_cycles", 32'(lat), 32'(want));
    chk("lat_data", 32'(v_resp_data[k]), 32'(cmp_fn(8'h80, 8'h7f, 3'd4)));
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cmp"}, 32'({cmp_a, cmp_b, cmp_sel}), 32'd0);
    chk({tag, "_resp"}, 32'({resp_data, resp_err}), 32'd0);
  endtask

  // Monitor: per-cycle grant/valid checks and scoreboard pop on response handshakes
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(exp_gnt));
      chk("busy", 32'(busy), 32'(mbusy));
      chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
      if (mbusy && mlegal && cyc < mdue && q.size() > 0) begin
        chk("cmp_a", 32'(cmp_a), 32'(q[0].a));
        chk("cmp_b", 32'(cmp_b), 32'(q[0].b));
        chk("cmp_sel", 32'(cmp_sel), 32'(q[0].sel));
      end else begin
        chk("cmp_idle", 32'({cmp_a, cmp_b, cmp_sel}), 32'd0);
      end
      if (resp_valid != 2'b00) begin
        if (q.size() == 0) begin
          chk("resp_unexpected", 32'(resp_valid), 32'd0);
        end else begin
          chk("resp_id", 32'(resp_valid), q[0].id ? 32'd2 : 32'd1);
          chk("resp_data", 32'(resp_data), 32'(q[0].data));
          chk("resp_err", 32'(resp_err), 32'(q[0].err));
          if ((resp_valid & resp_ready) != 2'b00) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b11; resp_ready = 2'b11;
    req_a_0 = '0; req_b_0 = '0; req_sel_0 = 3'd3;
    req_a_1 = '0; req_b_1 = '0; req_sel_1 = 3'd3;
    for (int k = 0; k < 2; k++) begin
      v_req_valid[k] = 2'b00; v_resp_ready[k] = 2'b11;
      v_a[k] = '0; v_b[k] = '0; v_sel[k] = 3'd0;
    end
    #12;
    check_all_zero("reset");
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    predict();
    chk_en = 1'b1;

    // Single request from requester 0: 5 < 9 -> 1
    tick();
    req_a_0 = 8'h05; req_b_0 = 8'h09; req_sel_0 = 3'd3; req_valid = 2'b01;
    predict();
    run_idle(20);

    // Continuous contention with legal selects: grants must alternate
    begin
      int start;
      start = n_acc;
      for (int i = 0; i < 200 && n_acc < start + 8; i++) begin
        tick();
        for (int j = 0; j < 2; j++)
          if (!req_valid[j]) new_req(j, 3'($urandom_range(7, 2)));
        predict();
      end
      chk("contention_accepts", 32'(n_acc - start), 32'd8);
      req_valid = 2'b00; predict();
      run_idle(20);
    end

    // Illegal select from requester 1
    tick();
    new_req(1, 3'd1);
    predict();
    run_idle(20);

    // Backpressure: hold off, wrong-bit ready, then release with a request waiting
    tick();
    new_req(1, 3'd5);
    resp_ready = 2'b00;
    predict();
    for (int i = 0; i < 20 && exp_rv == 2'b00; i++) tick();
    new_req(0, 3'd2);
    predict();
    repeat (5) tick();
    resp_ready = 2'b01;
    predict();
    tick();
    resp_ready = 2'b10;
    predict();
    begin
      int acc0;
      tick();
      acc0 = n_acc;
      resp_ready = 2'b11;
      predict();
      tick();
      chk("accept_after_release", 32'(n_acc - acc0), 32'd1);
    end
    run_idle(20);

    // Latency of the CMP_LAT=0 and CMP_LAT=3 builds
    measure(0, 2);
    measure(1, 5);

    // Randomized traffic with drops, operand churn and random backpressure
    for (int i = 0; i < 1500; i++) begin
      tick();
      for (int j = 0; j < 2; j++) begin
        if (!req_valid[j]) begin
          if ($urandom_range(3) == 0) new_req(j, 3'($urandom));
        end else if ($urandom_range(15) == 0) begin
          req_valid[j] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          new_req(j, 3'($urandom));
        end
      end
      resp_ready = {($urandom_range(3) != 0), ($urandom_range(3) != 0)};
      predict();
    end
    req_valid = 2'b00; resp_ready = 2'b11; predict();
    run_idle(50);
    chk("drain_queue", 32'(q.size()), 32'd0);

    // Reset in the middle of EXEC abandons the transaction
    tick();
    new_req(0, 3'd6);
    predict();
    tick();
    req_valid = 2'b11;
    predict();
    #2;
    rst_n = 1'b0;
    chk_en = 1'b0;
    #1;
    check_all_zero("midrst");
    mbusy = 1'b0; mlast = 1'b1; q.delete(); exp_gnt = 2'b00; exp_rv = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    predict();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_first_gnt", 32'(req_ready), 32'd1);
    run_idle(40);
    chk("rst_no_stale_resp", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
